// File: rtl/alu_if.sv
// Execute-stage ALU bus: operands/opcode in, registered result and flags out.
interface alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] result;
    logic             out_valid;
    logic             zero;
    logic             negative;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, a, b, alu_op,
        input  result, out_valid, zero, negative, carry, overflow
    );

    modport slave (
        input  in_valid, a, b, alu_op,
        output result, out_valid, zero, negative, carry, overflow
    );
endinterface

// File: rtl/alu.sv
// Registered integer ALU, one-cycle latency, 1 op/cycle.
// Define ALU_MUL_EN to enable opcode 1011 (low half of unsigned a*b).
module alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input logic  clk,
    input logic  rst,
    alu_if.slave bus
);
    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_NOR  = 4'b0101,
        OP_SLT  = 4'b0110,
        OP_SLTU = 4'b0111,
        OP_SLL  = 4'b1000,
        OP_SRL  = 4'b1001,
        OP_SRA  = 4'b1010,
        OP_MUL  = 4'b1011
    } op_e;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             ovf_d;

    assign sum   = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff  = {1'b0, bus.a} - {1'b0, bus.b};
    assign shamt = bus.b[SHW-1:0];

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (op_e'(bus.alu_op))
            OP_ADD: begin
                res_d   = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
                ovf_d   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                // carry is NOT borrow, i.e. a >= b unsigned
                res_d   = diff[WIDTH-1:0];
                carry_d = ~diff[WIDTH];
                ovf_d   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  res_d = bus.a & bus.b;
            OP_OR:   res_d = bus.a | bus.b;
            OP_XOR:  res_d = bus.a ^ bus.b;
            OP_NOR:  res_d = ~(bus.a | bus.b);
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_SLL:  res_d = bus.a << shamt;
            OP_SRL:  res_d = bus.a >> shamt;
            OP_SRA:  res_d = $signed(bus.a) >>> shamt;
`ifdef ALU_MUL_EN
            OP_MUL:  res_d = bus.a * bus.b;
`else
            OP_MUL:  res_d = '0;
`endif
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.result    <= '0;
            bus.zero      <= 1'b0;
            bus.negative  <= 1'b0;
            bus.carry     <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.result   <= res_d;
                bus.zero     <= (res_d == '0);
                bus.negative <= res_d[WIDTH-1];
                bus.carry    <= carry_d;
                bus.overflow <= ovf_d;
            end
        end
    end
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, corner sequences,
// and randomized ops against an arithmetic reference model.
module tb_alu;
    localparam int W = 32;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    alu_if #(.WIDTH(W)) bus ();
    alu #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: flags derived from wide arithmetic, not bit tricks.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t            e;
        longint unsigned ua, ub, us;
        longint          sa, sb, ss;
        logic [W-1:0]    lo;
        int              sh;
        ua = 64'(a);
        ub = 64'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % W);
        e  = '{default: '0};
        case (op)
            4'd0: begin
                us = ua + ub; e.res = us[W-1:0]; e.c = (us > 64'hFFFF_FFFF);
                ss = sa + sb; lo = ss[W-1:0]; e.v = (ss != longint'($signed(lo)));
            end
            4'd1: begin
                us = ua - ub; e.res = us[W-1:0]; e.c = (a >= b);
                ss = sa - sb; lo = ss[W-1:0]; e.v = (ss != longint'($signed(lo)));
            end
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = a ^ b;
            4'd5: e.res = ~(a | b);
            4'd6: e.res = (sa < sb) ? 1 : 0;
            4'd7: e.res = (ua < ub) ? 1 : 0;
            4'd8: begin us = ua << sh; e.res = us[W-1:0]; end
            4'd9: begin us = ua >> sh; e.res = us[W-1:0]; end
            4'd10: begin ss = sa >>> sh; e.res = ss[W-1:0]; end
`ifdef ALU_MUL_EN
            4'd11: begin us = ua * ub; e.res = us[W-1:0]; end
`endif
            default: e.res = '0;
        endcase
        e.z = (e.res == '0);
        e.n = e.res[W-1];
        return e;
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.in_valid = v;
        bus.alu_op   = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ov, input exp_t e);
        chk({tag, ".out_valid"}, W'(bus.out_valid), W'(ov));
        chk({tag, ".result"},    bus.result,        e.res);
        chk({tag, ".zero"},      W'(bus.zero),      W'(e.z));
        chk({tag, ".negative"},  W'(bus.negative),  W'(e.n));
        chk({tag, ".carry"},     W'(bus.carry),     W'(e.c));
        chk({tag, ".overflow"},  W'(bus.overflow),  W'(e.v));
    endtask

    initial begin
        vec_t tbl[$];
        exp_t e, held;
        exp_t zero_e;
        logic [3:0] op;
        logic [W-1:0] ra, rb;

        zero_e = '{default: '0};
        bus.in_valid = 1'b1;
        bus.alu_op   = 4'd0;
        bus.a        = 32'h1234_5678;
        bus.b        = 32'h1111_1111;

        //           op     a             b             res           z n c v
        tbl.push_back('{4'd0, 32'h06A0A5A5, 32'h0A5A6A5A, 32'h10FB0FFF, 0,0,0,0});
        tbl.push_back('{4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1,0,1,0});
        tbl.push_back('{4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0,1,0,1});
        tbl.push_back('{4'd1, 32'h0000000F, 32'h00000001, 32'h0000000E, 0,0,1,0});
        tbl.push_back('{4'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0,1,0,0});
        tbl.push_back('{4'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0,0,1,1});
        tbl.push_back('{4'd2, 32'h000000FF, 32'h0000FFFF, 32'h000000FF, 0,0,0,0});
        tbl.push_back('{4'd3, 32'hFF00FF00, 32'h00FF00FF, 32'hFFFFFFFF, 0,1,0,0});
        tbl.push_back('{4'd4, 32'h11111111, 32'h00000000, 32'h11111111, 0,0,0,0});
        tbl.push_back('{4'd5, 32'hFFFFFFFF, 32'h12345678, 32'h00000000, 1,0,0,0});
        tbl.push_back('{4'd6, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0,0,0,0});
        tbl.push_back('{4'd7, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1,0,0,0});
        tbl.push_back('{4'd8, 32'h00000001, 32'h0000003F, 32'h80000000, 0,1,0,0});
        tbl.push_back('{4'd10, 32'h80000000, 32'h00000004, 32'hF8000000, 0,1,0,0});
        tbl.push_back('{4'd9, 32'h80000000, 32'h00000004, 32'h08000000, 0,0,0,0});
        tbl.push_back('{4'd9, 32'h80000000, 32'hFFFFFFE4, 32'h08000000, 0,0,0,0});
`ifdef ALU_MUL_EN
        tbl.push_back('{4'd11, 32'h00010000, 32'h00010000, 32'h00000000, 1,0,0,0});
        tbl.push_back('{4'd11, 32'h00000003, 32'h00000005, 32'h0000000F, 0,0,0,0});
`else
        tbl.push_back('{4'd11, 32'h00000003, 32'h00000005, 32'h00000000, 1,0,0,0});
`endif
        tbl.push_back('{4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1,0,0,0});
        tbl.push_back('{4'd15, 32'h00000003, 32'h00000005, 32'h00000000, 1,0,0,0});

        // Reset held two cycles with in_valid high: everything stays cleared.
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_out("reset", 1'b0, zero_e);

        // First op after release lands one cycle later.
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.alu_op = 4'd0; bus.a = 32'd2; bus.b = 32'd3;
        @(posedge clk); #1;
        e = model(4'd0, 32'd2, 32'd3);
        chk_out("first_op", 1'b1, e);

        // Directed table, issued back to back.
        foreach (tbl[i]) begin
            drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
            e = '{tbl[i].res, tbl[i].z, tbl[i].n, tbl[i].c, tbl[i].v};
            chk_out($sformatf("vec%0d", i), 1'b1, e);
        end

        // Single pulse then idle: out_valid for one cycle, result/flags hold.
        drive(1'b1, 4'd0, 32'h7FFFFFFF, 32'h00000001);
        held = model(4'd0, 32'h7FFFFFFF, 32'h00000001);
        chk_out("pulse", 1'b1, held);
        drive(1'b0, 4'd2, 32'h0, 32'h0);
        chk_out("idle1", 1'b0, held);
        drive(1'b0, 4'd1, 32'h5, 32'h9);
        chk_out("idle2", 1'b0, held);

        // Reset wins over a concurrent valid op.
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.alu_op = 4'd3; bus.a = 32'hF0F0F0F0; bus.b = 32'h1;
        @(posedge clk); #1;
        chk_out("mid_reset", 1'b0, zero_e);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;

        // Random ops with occasional idle cycles.
        held = zero_e;
        for (int k = 0; k < 400; k++) begin
            logic v;
            v  = ($urandom_range(0, 7) != 0);
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: ra = 32'h8000_0000 ^ 32'($urandom_range(0, 1));
                1: ra = 32'h7FFF_FFFF - 32'($urandom_range(0, 1));
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            drive(v, op, ra, rb);
            if (v) held = model(op, ra, rb);
            chk_out($sformatf("rand%0d_op%0d", k, op), v, held);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
